// File: rtl/chip8_pkg.sv
// rtl/chip8_pkg.sv - shared CHIP-8 video constants and scanout state encodings
package chip8_pkg;

   localparam int VRAM_ADDR_WIDTH = 11;
   localparam int VRAM_DATA_WIDTH = 2;
   localparam int SCREEN_W        = 64;
   localparam int SCREEN_H        = 32;

   localparam logic [1:0] ST_VBLANK = 2'd0;
   localparam logic [1:0] ST_LINE   = 2'd1;
   localparam logic [1:0] ST_HBLANK = 2'd2;

   // Framebuffer cell coordinate to VRAM word address, row-major.
   function automatic logic [VRAM_ADDR_WIDTH-1:0] cell_addr(input logic [4:0] y, input logic [5:0] x);
      return {y, x};
   endfunction

endpackage

// File: rtl/scale_ctr.sv
// rtl/scale_ctr.sv - sub-pixel counter wrapping at SCALE feeding a saturating cell counter
module scale_ctr #(
   parameter int SCALE = 10,
   parameter int CELLS = 64,
   parameter int SW    = $clog2(SCALE),
   parameter int CW    = $clog2(CELLS + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr_i,
   input  logic          step_i,
   output logic [SW-1:0] sub_o,
   output logic [CW-1:0] cell_o
);

   logic [SW-1:0] sub_q, sub_d;
   logic [CW-1:0] cell_q, cell_d;

   // Clear wins over step; the cell count sticks at CELLS so an oversized window never wraps.
   always_comb begin
      sub_d  = sub_q;
      cell_d = cell_q;
      if (clr_i) begin
         sub_d  = '0;
         cell_d = '0;
      end else if (step_i) begin
         if (sub_q == SW'(SCALE - 1)) begin
            sub_d = '0;
            if (cell_q != CW'(CELLS)) begin
               cell_d = cell_q + 1'b1;
            end
         end else begin
            sub_d = sub_q + 1'b1;
         end
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sub_q  <= '0;
         cell_q <= '0;
      end else begin
         sub_q  <= sub_d;
         cell_q <= cell_d;
      end
   end

   assign sub_o  = sub_q;
   assign cell_o = cell_q;

endmodule

// File: rtl/vram_scanout.sv
// rtl/vram_scanout.sv - VRAM raster scanout with upscaling and aligned syncs; SCANOUT_GRID_EN adds a debug cell grid
module vram_scanout
   import chip8_pkg::*;
#(
   parameter int H_SCALE = 10,
   parameter int V_SCALE = 15
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       hs_in,
   input  logic                       hs_valid,
   input  logic                       vs_in,
   input  logic                       vs_valid,
   output logic [VRAM_ADDR_WIDTH-1:0] vram_raddr,
   input  logic [VRAM_DATA_WIDTH-1:0] vram_q,
   output logic                       pix,
   output logic                       hs_o,
   output logic                       vs_o
);

   localparam int XW  = $clog2(SCREEN_W + 1);
   localparam int YW  = $clog2(SCREEN_H + 1);
   localparam int SXW = $clog2(H_SCALE);
   localparam int SYW = $clog2(V_SCALE);

   logic [1:0]  state_q, state_d;
   logic        synced_q, synced_d;
   logic [VRAM_ADDR_WIDTH-1:0] raddr_q, raddr_d;
   logic [1:0]  hs_q, vs_q, active_q, in_range_q;
   logic        active, in_range;
   logic        clr_x, step_x, clr_y, step_y;
   logic [SXW-1:0] sub_x;
   logic [SYW-1:0] sub_y;
   logic [XW-1:0]  x_cell;
   logic [YW-1:0]  y_cell;
   logic        unused_ok;

   assign active = hs_valid & vs_valid;

   // synced_q blocks any partial frame after reset until a vertical blank has been seen.
   assign in_range = synced_q & (x_cell < XW'(SCREEN_W)) & (y_cell < YW'(SCREEN_H));
   assign synced_d = synced_q | ~vs_valid;

   // Raster walk: decides the next state and how the x/y counters move this cycle.
   always_comb begin
      state_d = state_q;
      clr_x   = 1'b0;
      step_x  = 1'b0;
      clr_y   = 1'b0;
      step_y  = 1'b0;
      case (state_q)
         ST_VBLANK: begin
            clr_y = 1'b1;
            if (active && synced_q) begin
               state_d = ST_LINE;
               step_x  = 1'b1;
            end else begin
               clr_x = 1'b1;
            end
         end
         ST_LINE: begin
            if (!vs_valid) begin
               state_d = ST_VBLANK;
               clr_x   = 1'b1;
               clr_y   = 1'b1;
            end else if (!hs_valid) begin
               state_d = ST_HBLANK;
               clr_x   = 1'b1;
               step_y  = 1'b1;
            end else begin
               step_x = 1'b1;
            end
         end
         ST_HBLANK: begin
            if (!vs_valid) begin
               state_d = ST_VBLANK;
               clr_x   = 1'b1;
               clr_y   = 1'b1;
            end else if (active) begin
               state_d = ST_LINE;
               step_x  = 1'b1;
            end
         end
         default: begin
            state_d = ST_VBLANK;
            clr_x   = 1'b1;
            clr_y   = 1'b1;
         end
      endcase
   end

   // Address only follows in-range active cells, so a saturated x never wraps back to column 0.
   always_comb begin
      raddr_d = raddr_q;
      if (active && in_range) begin
         raddr_d = cell_addr(y_cell[4:0], x_cell[5:0]);
      end
   end

   scale_ctr #(.SCALE(H_SCALE), .CELLS(SCREEN_W)) u_x_ctr (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (clr_x),
      .step_i (step_x),
      .sub_o  (sub_x),
      .cell_o (x_cell)
   );

   scale_ctr #(.SCALE(V_SCALE), .CELLS(SCREEN_H)) u_y_ctr (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (clr_y),
      .step_i (step_y),
      .sub_o  (sub_y),
      .cell_o (y_cell)
   );

   // State, address and the two-stage delay lines matching the VRAM read latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_VBLANK;
         synced_q   <= 1'b0;
         raddr_q    <= '0;
         hs_q       <= 2'b11;
         vs_q       <= 2'b11;
         active_q   <= 2'b00;
         in_range_q <= 2'b00;
      end else begin
         state_q    <= state_d;
         synced_q   <= synced_d;
         raddr_q    <= raddr_d;
         hs_q       <= {hs_q[0], hs_in};
         vs_q       <= {vs_q[0], vs_in};
         active_q   <= {active_q[0], active};
         in_range_q <= {in_range_q[0], in_range};
      end
   end

   assign vram_raddr = raddr_q;
   assign hs_o       = hs_q[1];
   assign vs_o       = vs_q[1];

`ifdef SCANOUT_GRID_EN
   logic       grid;
   logic [1:0] grid_q;

   assign grid = (sub_x == '0) | (sub_y == '0);

   // Grid flag delayed alongside the address so it lands on the same pixel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grid_q <= 2'b00;
      end else begin
         grid_q <= {grid_q[0], grid};
      end
   end

   assign pix       = (vram_q[0] ^ grid_q[1]) & active_q[1] & in_range_q[1];
   assign unused_ok = vram_q[1];
`else
   // vram_q is already a register output, so pix lines up with the second delay tap.
   assign pix       = vram_q[0] & active_q[1] & in_range_q[1];
   assign unused_ok = ^{vram_q[1], sub_x, sub_y};
`endif

endmodule

// File: doc/vram_scanout.md
# vram_scanout

Display read-side of the CHIP-8 video RAM. Walks the 64x32 1-bit framebuffer in raster order in step with the `vga` timing generator, and upscales each framebuffer cell to H_SCALE x V_SCALE screen pixels. Drives one monochrome pixel bit plus sync outputs, both delayed to match the VRAM read latency. Sits between the VRAM read port and the VGA pins; the sprite writer owns the write port.

## Interface
- H_SCALE, 10, screen pixels per framebuffer column (64*10 = 640)
- V_SCALE, 15, screen lines per framebuffer row (32*15 = 480)
- clk  in  1  system clock (same clock as `vga` and the VRAM)
- rst_n  in  1  asynchronous active-low reset
- hs_in  in  1  horizontal sync from `vga`
- hs_valid  in  1  horizontal active-video window from `vga`
- vs_in  in  1  vertical sync from `vga`
- vs_valid  in  1  vertical active-video window from `vga`
- vram_raddr  out  11  VRAM read address {y[4:0], x[5:0]}
- vram_q  in  2  VRAM read data; bit 0 is the pixel, bit 1 ignored
- pix  out  1  pixel output, 1 = lit
- hs_o  out  1  hs_in delayed to align with pix
- vs_o  out  1  vs_in delayed to align with pix

## Operation
- active = hs_valid & vs_valid.
- State machine:
  - ST_VBLANK: entered on reset and whenever vs_valid = 0. Clears x, sub_x, y, sub_y. Goes to ST_LINE when active = 1.
  - ST_LINE: each cycle, sub_x increments. When sub_x = H_SCALE-1, sub_x wraps to 0 and x increments. Goes to ST_HBLANK when hs_valid = 0.
  - ST_HBLANK: entered from the falling edge of hs_valid.
    - On entry, x and sub_x clear and sub_y increments.
    - When sub_y = V_SCALE-1, sub_y wraps to 0 and y increments.
    - Goes to ST_LINE on the next active cycle.
    - Goes to ST_VBLANK if vs_valid = 0.
- x is 7 bits and saturates at 64. y is 6 bits and saturates at 32.
  - in_range = (x < 64) & (y < 32).
  - Out-of-range cells output pix = 0. This covers the case where the `vga` window exceeds 640x480.
- vram_raddr = {y[4:0], x[5:0]}, registered. It holds its last value outside ST_LINE.
- pix = vram_q[0] & active_d2 & in_range_d2.
- The block never writes VRAM and has no handshake with the sprite writer. Tearing during a draw is accepted.

## Timing
- Latency from active/counters to pix is 2 cycles:
  - cycle 0: address registered;
  - cycle 1: VRAM registered read;
  - cycle 2: pix registered.
- hs_in, vs_in, active and in_range pass through matching 2-stage delay lines, so pix, hs_o and vs_o stay cycle-aligned.
- Reset values:
  - pix = 0
  - hs_o = 1, vs_o = 1 (syncs are negative polarity, so 1 is inactive)
  - vram_raddr = 0
  - all counters 0
  - state = ST_VBLANK
  - delay lines: sync taps 1, valid taps 0
- Reset asserted mid-line: outputs take their reset values immediately. After release, the block waits in ST_VBLANK for the next vs_valid rise. No partial frame is emitted.
- vs_valid falling during ST_LINE: go to ST_VBLANK on the next clock. pix is still gated correctly by active_d2.
- Simultaneous sub_x and x wrap at the last cell of a line: x saturates and no address wrap-around occurs.

## Configuration
- SCANOUT_GRID_EN defined: pix = (vram_q[0] ^ grid_d2) & active_d2 & in_range_d2, where grid = (sub_x == 0) | (sub_y == 0). This draws a cell grid for debug.
- SCANOUT_GRID_EN undefined: there is no grid logic and pix is exactly as in Operation.

## Structure
- Shared package `chip8_pkg` holds:
  - VRAM_ADDR_WIDTH = 11, VRAM_DATA_WIDTH = 2
  - SCREEN_W = 64, SCREEN_H = 32
  - state encodings ST_VBLANK, ST_LINE, ST_HBLANK
- One sub-module, `scale_ctr`: a sub-counter wrapping at a SCALE parameter plus a saturating cell counter, with clear/step inputs. It is instantiated twice, for x and for y.

## Test plan
- Framebuffer all zeros, one full frame -> pix = 0 every cycle; hs_o/vs_o equal hs_in/vs_in delayed by exactly 2 cycles.
- Only cell (x=0,y=0) set -> pix = 1 on the first 10 active cycles of each of the first 15 active lines, 2 cycles after hs_valid rises; 0 elsewhere.
- Only cell (63,31) set -> vram_raddr = 0x7FF observed; pix = 1 on the last 10 pixels of lines 465-479.
- Assert rst_n low mid-line 200 -> pix = 0 and hs_o = vs_o = 1 immediately; after release, pix stays 0 until the next vs_valid rise, then the frame is correct.
- `vga` window stretched to 700 active pixels -> pixels 640-699 give pix = 0 and x stays at 64.
- With SCANOUT_GRID_EN and an empty framebuffer -> pix = 1 at every 10th pixel and on every 15th line.
